voice_alloc: RTL
================

# voice_alloc

- Polyphonic voice allocator that owns the voice-active mask of the oscillator bank.
- Accepts serialized note-on/note-off requests and scans the voice table serially, one voice per cycle.
- Assigns, retriggers, steals or releases a voice, and writes the resulting mask on `voice_active_o`.
- That mask is the word the `bitcount` block counts to report the number of sounding voices.

## Interface

Parameters:
- VOICES, default `OSC_VOICES: number of voices; must be ≥ 2.
- NOTE_W, default 7: note number width (MIDI).
- IDX_W: derived, $clog2(VOICES); not overridable.

Ports:
- clk_i, input, 1: single clock; all state updates on its rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- req_valid_i, input, 1: request present.
- req_ready_o, output, 1: high only in IDLE and not in reset.
- req_on_i, input, 1: 1 = note-on, 0 = note-off.
- req_note_i, input, NOTE_W: note number of the request.
- rsp_valid_o, output, 1: one-cycle result pulse.
- rsp_ok_o, output, 1: request honoured; valid with rsp_valid_o.
- rsp_voice_o, output, IDX_W: voice affected; valid with rsp_valid_o.
- voice_active_o, output, VOICES: registered active mask; drives bitcount word_i.
- voice_note_o, output, VOICES*NOTE_W: note per voice; voice k at bits [k*NOTE_W +: NOTE_W].
- voice_trig_o, output, VOICES: one-cycle pulse on the voice (re)triggered by a note-on.

## Operation

- FSM states: IDLE, SCAN, COMMIT.
- IDLE → SCAN when req_valid_i && req_ready_o.
  - req_on_i and req_note_i are latched in that cycle.
  - Scan index and scan flags clear in that cycle.
- SCAN examines voice idx = 0 … VOICES-1, one voice per cycle, and records:
  - match: lowest idx with active[idx] && note[idx] == latched note.
  - free: lowest idx with !active[idx].
- SCAN → COMMIT after idx = VOICES-1 is examined.
- COMMIT → IDLE unconditionally; this is the only cycle rsp_valid_o = 1.
- Note-on resolution, by priority:
  1. match: retrigger that voice. Mask and note are unchanged; trig pulse; ok = 1.
  2. Else free: set active[free] and note[free]; trig pulse; ok = 1.
  3. Else steal: voice = steal_ptr. Overwrite note, keep active, trig pulse, ok = 1.
- steal_ptr increments modulo VOICES, and only on a steal (wraps VOICES-1 → 0).
- Note-off:
  - match: clear active[match]; note[match] is retained; ok = 1; no trig.
  - No match: no state change, ok = 0, rsp_voice_o = 0.
- Mask, note and trig updates take effect at the COMMIT edge, so they are visible the cycle after COMMIT.
- Reset values:
  - state = IDLE; voice_active_o = 0; all notes = 0; steal_ptr = 0.
  - rsp_valid_o = 0, rsp_ok_o = 0, rsp_voice_o = 0, voice_trig_o = 0.
  - req_ready_o = 0 while rst_i is high, and 1 on the first cycle after reset releases.
- Reset in SCAN or COMMIT aborts the request: no rsp_valid_o, no mask update.
- Requests are never queued: req_valid_i while req_ready_o = 0 is ignored.

## Timing

- Handshake cycle T: acceptance edge.
- T+1 … T+VOICES: SCAN.
- T+VOICES+1: COMMIT. rsp_valid_o high, rsp_ok_o and rsp_voice_o valid, req_ready_o = 0.
- T+VOICES+2: IDLE.
  - voice_active_o, voice_note_o and voice_trig_o show the new values.
  - voice_trig_o is high for exactly this cycle.
  - req_ready_o = 1.
- Latency from accept to response: VOICES+1 cycles.
- Minimum request spacing: VOICES+2 cycles.
- rsp_valid_o has no backpressure; the consumer must sample it in its single cycle.
- All outputs are registered or decoded from the state register; there is no combinational path from request inputs to any output.

## Test plan

Bench uses VOICES = 4, NOTE_W = 7.

1. Reset held 3 cycles, then released:
   - During reset: req_ready_o = 0.
   - After release: voice_active_o = 4'b0000, rsp_valid_o = 0, req_ready_o = 1.
2. Note-on 60, then 64, then 67:
   - rsp_voice_o = 0, 1, 2 respectively, all ok = 1.
   - Each rsp_valid_o occurs 5 cycles after accept.
   - Final voice_active_o = 4'b0111; bitcount count_o = 3.
3. Note-on 60 again: rsp_voice_o = 0, ok = 1, voice_trig_o = 4'b0001 for one cycle, mask unchanged at 4'b0111.
4. Note-on 72 then 74:
   - 72 → voice 3, mask 4'b1111.
   - 74 → steal voice 0 (note[0] = 74, steal_ptr becomes 1).
   - A further note-on 76 → steals voice 1.
5. Note-off sequence from state 4 (notes 74, 76, 67, 72):
   - Note-off 67: voice 2 cleared, mask 4'b1011, ok = 1.
   - Note-off 99: ok = 0, mask unchanged.
   - Next note-on 50: takes free voice 2.
6. Reset during SCAN (2 cycles after accept) and protocol abuse:
   - No rsp_valid_o; voice_active_o = 0 the cycle after reset.
   - req_valid_i pulsed while busy: ignored, with no extra response.

Source files
------------

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: serial note-on/off requests scan the voice table one voice per cycle,
// then retrigger, assign, steal or release a voice and publish the active mask and per-voice notes.
`ifndef OSC_VOICES
`define OSC_VOICES 8
`endif

module voice_alloc #(
  parameter  int VOICES = `OSC_VOICES,
  parameter  int NOTE_W = 7,
  localparam int IDX_W  = $clog2(VOICES)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_on_i,
  input  logic [NOTE_W-1:0]        req_note_i,
  output logic                     rsp_valid_o,
  output logic                     rsp_ok_o,
  output logic [IDX_W-1:0]         rsp_voice_o,
  output logic [VOICES-1:0]        voice_active_o,
  output logic [VOICES*NOTE_W-1:0] voice_note_o,
  output logic [VOICES-1:0]        voice_trig_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [VOICES-1:0] r_active;
  logic [NOTE_W-1:0] r_note [VOICES];
  logic [VOICES-1:0] r_trig;
  logic [IDX_W-1:0]  r_steal;

  logic              r_req_on;
  logic [NOTE_W-1:0] r_req_note;
  logic [IDX_W-1:0]  r_idx;
  logic              r_match_found;
  logic [IDX_W-1:0]  r_match_idx;
  logic              r_free_found;
  logic [IDX_W-1:0]  r_free_idx;

  logic              w_accept;
  logic              w_last;
  logic [IDX_W-1:0]  w_voice;
  logic              w_ok;

  assign req_ready_o = (r_state == IDLE) && !rst_i;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_last      = (r_idx == IDX_W'(VOICES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SCAN;
      SCAN:    if (w_last) w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Resolution priority: matching voice, then lowest free voice, then the steal pointer.
  always_comb begin
    w_voice = '0;
    w_ok    = 1'b0;
    if (r_req_on) begin
      w_ok = 1'b1;
      if (r_match_found)     w_voice = r_match_idx;
      else if (r_free_found) w_voice = r_free_idx;
      else                   w_voice = r_steal;
    end else if (r_match_found) begin
      w_ok    = 1'b1;
      w_voice = r_match_idx;
    end
  end

  assign rsp_valid_o = (r_state == COMMIT);
  assign rsp_ok_o    = rsp_valid_o && w_ok;
  assign rsp_voice_o = rsp_valid_o ? w_voice : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active      <= '0;
      r_trig        <= '0;
      r_steal       <= '0;
      r_req_on      <= 1'b0;
      r_req_note    <= '0;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      for (int k = 0; k < VOICES; k++) r_note[k] <= '0;
    end else begin
      r_trig <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_on      <= req_on_i;
            r_req_note    <= req_note_i;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
          end
        end
        SCAN: begin
          if (!r_match_found && r_active[r_idx] && (r_note[r_idx] == r_req_note)) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (!r_free_found && !r_active[r_idx]) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        COMMIT: begin
          if (r_req_on) begin
            r_trig[w_voice] <= 1'b1;
            if (!r_match_found) begin
              r_note[w_voice] <= r_req_note;
              if (r_free_found) begin
                r_active[w_voice] <= 1'b1;
              end else begin
                r_steal <= (r_steal == IDX_W'(VOICES - 1)) ? '0 : r_steal + 1'b1;
              end
            end
          end else if (r_match_found) begin
            r_active[r_match_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign voice_active_o = r_active;
  assign voice_trig_o   = r_trig;

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_note_out
    assign voice_note_o[gi*NOTE_W +: NOTE_W] = r_note[gi];
  end

endmodule
